trace_stream_arbiter: RTL
=========================

Name: trace_stream_arbiter

Overview:
- Shares one cpu_checker-style character parser between N_SRC CPU trace sources.
- Each source offers a byte stream of messages that start with "^" and end with "#". The arbiter grants one source per whole message, round-robin, and forwards its characters to the checker.
- It samples the checker's format_type after each "#" and keeps per-source saturating counters of register-write, memory-write and invalid/aborted messages.

Parameters:
- N_SRC, 4, number of trace sources (2..8)
- SRC_W, 2, width of a source index; must equal clog2(N_SRC)
- MAX_LEN, 64, maximum characters per message, "^" and "#" included
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- src_valid  in  N_SRC  source i presents a character
- src_char  in  8*N_SRC  character of source i, in bits [8i+7:8i]
- src_ready  out  N_SRC  character of source i consumed this cycle (combinational)
- chk_char  out  8  registered character driven to the checker's char input
- fmt_type  in  2  checker format_type (0 invalid, 1 register, 2 memory)
- result_valid  out  1  one-cycle pulse: message finished
- result_src  out  SRC_W  source of the finished message
- result_type  out  2  sampled fmt_type; 0 on abort
- result_abort  out  1  message was aborted (gap or overflow)
- cnt_sel  in  SRC_W  statistics source select
- cnt_reg  out  CNT_W  type-1 count of the selected source (combinational read)
- cnt_mem  out  CNT_W  type-2 count of the selected source
- cnt_bad  out  CNT_W  type-0 or aborted count of the selected source

Behaviour:
- Reset values:
  - state IDLE
  - chk_char 8'h00
  - src_ready 0; result_valid, result_abort, result_type, result_src 0
  - all counters 0
  - rr pointer last = N_SRC-1, so source 0 has first priority
- Filler: chk_char = 8'h00 whenever no character is forwarded.
- States:
  - IDLE:
    - Candidates: sources with src_valid=1 and src_char="^".
    - Winner: the first candidate scanning last+1, last+2, ... modulo N_SRC.
    - For the winner: src_ready=1, chk_char<="^", g<=winner, last<=winner, len<=1, go to STREAM.
    - Any non-winner source with valid=1 and char != "^" is drained that cycle: ready=1, char discarded, nothing forwarded.
    - No candidate: stay in IDLE, filler.
  - STREAM:
    - src_valid[g]=1 and len<MAX_LEN: ready[g]=1, chk_char<=char, len++. If char="#", go to FLUSH.
    - "^" inside a message is forwarded with no special handling.
    - src_valid[g]=0 (gap), or len==MAX_LEN with a non-"#" char pending (that char is not accepted): chk_char<=0, abort. Set result_valid, result_abort=1, result_type=0, result_src=g; cnt_bad[g]++; go to IDLE.
    - All other sources have ready=0.
  - FLUSH: chk_char<=0 (checker latches "#" this edge); go to RESULT.
  - RESULT:
    - fmt_type is valid in this cycle.
    - Register result_valid=1, result_type=fmt_type, result_abort=0, result_src=g.
    - Increment cnt_reg / cnt_mem / cnt_bad of g according to fmt_type (3 counts as bad).
    - Go to IDLE.
- Latency:
  - "^" accepted at edge e appears on chk_char during cycle e+1.
  - "#" accepted at edge k: result_valid is high during the cycle after edge k+2.
  - An L-character message occupies L+3 cycles, so a new grant is possible at edge k+3.
- result_valid is high for exactly one cycle.
- Counters saturate at 2^CNT_W-1.
- Arbitration decisions are made only in IDLE; no preemption during a message.
- Reset mid-message: immediate return to reset values. The partial message is not counted and no result is produced.

Decomposition:
- Package trace_pkg:
  - character constants CH_START "^", CH_END "#", CH_NUL 8'h00
  - format codes FMT_BAD 0, FMT_REG 1, FMT_MEM 2
  - state enum IDLE, STREAM, FLUSH, RESULT
- Sub-module rr_picker: combinational round-robin (req vector, last) -> (any, winner index). Reused by future shared-resource blocks.

Test Plan:
- src0 sends "^10@00003000: $ 1 <= 00001234#" with valid held, checker model attached:
  - chk_char reproduces the string, one character per cycle.
  - result_valid pulses once, 3 cycles after "#" is accepted: result_src 0, type 1.
  - cnt_reg[0]=1.
- src1 sends "^5@0000300c: *00000010 <= 0000abcd#": result type 2, cnt_mem[1]=1.
- src0 and src2 both present "^" in the same IDLE cycle:
  - src0 is served first, then src2.
  - Both request again: src0 wins (last=2), and the message order is 0,2,0.
- src3 drops valid after 6 characters:
  - next chk_char is 00.
  - result_valid with abort=1, type 0.
  - cnt_bad[3]=1; src3 gets no grant until it next presents "^".
- src1 presents "xy" in IDLE: both characters drained over 2 cycles (ready=1), chk_char stays 00, no result pulse.
- src2 sends "^1@00000000: $" followed by 60 spaces: abort at len=64, overflow character not consumed, cnt_bad[2]=1.
- Reset asserted mid-STREAM: next cycle chk_char=00, src_ready=0, all counters 0.

Source files
------------

// File: rtl/trace_stream_arbiter_pkg.sv
// Shared constants and state encoding for the trace stream arbiter.
// Character codes match the cpu_checker message framing.
package trace_pkg;

  localparam logic [7:0] CH_START = 8'h5E;
  localparam logic [7:0] CH_END   = 8'h23;
  localparam logic [7:0] CH_NUL   = 8'h00;

  localparam logic [1:0] FMT_BAD = 2'd0;
  localparam logic [1:0] FMT_REG = 2'd1;
  localparam logic [1:0] FMT_MEM = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    RESULT
  } state_e;

endpackage

// File: rtl/trace_stream_arbiter_rr_picker.sv
// Combinational round-robin picker: first request after the last
// winner, wrapping modulo N.
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    int j;
    any_o = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_i) + k) % N;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = W'(j);
      end
    end
  end

endmodule

// File: rtl/trace_stream_arbiter.sv
// Shares one trace character checker between N_SRC sources, one whole
// message per grant, and keeps per-source message statistics.
import trace_pkg::*;

module trace_stream_arbiter #(
  parameter int N_SRC   = 4,
  parameter int SRC_W   = 2,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   src_valid,
  input  logic [8*N_SRC-1:0] src_char,
  output logic [N_SRC-1:0]   src_ready,
  output logic [7:0]         chk_char,
  input  logic [1:0]         fmt_type,
  output logic               result_valid,
  output logic [SRC_W-1:0]   result_src,
  output logic [1:0]         result_type,
  output logic               result_abort,
  input  logic [SRC_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]   cnt_reg,
  output logic [CNT_W-1:0]   cnt_mem,
  output logic [CNT_W-1:0]   cnt_bad
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   g_q, g_d;
  logic [SRC_W-1:0]   last_q, last_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         chk_q, chk_d;
  logic               rv_q, rv_d;
  logic [SRC_W-1:0]   rs_q, rs_d;
  logic [1:0]         rt_q, rt_d;
  logic               ra_q, ra_d;

  logic [7:0]         ch [N_SRC];
  logic [N_SRC-1:0]   cand;
  logic [N_SRC-1:0]   ready;
  logic               any;
  logic [SRC_W-1:0]   win;
  logic               inc_reg, inc_mem, inc_bad;

  logic [CNT_W-1:0]   cnt_reg_q [N_SRC];
  logic [CNT_W-1:0]   cnt_mem_q [N_SRC];
  logic [CNT_W-1:0]   cnt_bad_q [N_SRC];

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      ch[i]   = src_char[8*i +: 8];
      cand[i] = src_valid[i] && (ch[i] == CH_START);
    end
  end

  rr_picker #(
    .N (N_SRC),
    .W (SRC_W)
  ) u_pick (
    .req_i  (cand),
    .last_i (last_q),
    .any_o  (any),
    .idx_o  (win)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    len_d   = len_q;
    chk_d   = CH_NUL;
    rv_d    = 1'b0;
    rs_d    = rs_q;
    rt_d    = rt_q;
    ra_d    = ra_q;
    ready   = '0;
    inc_reg = 1'b0;
    inc_mem = 1'b0;
    inc_bad = 1'b0;
    unique case (state_q)
      IDLE: begin
        // stray characters outside a message are drained
        for (int i = 0; i < N_SRC; i++) begin
          if (src_valid[i] && ch[i] != CH_START) begin
            ready[i] = 1'b1;
          end
        end
        if (any) begin
          ready[win] = 1'b1;
          chk_d      = CH_START;
          g_d        = win;
          last_d     = win;
          len_d      = LEN_W'(1);
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (src_valid[g_q] && len_q < LEN_W'(MAX_LEN)) begin
          ready[g_q] = 1'b1;
          chk_d      = ch[g_q];
          len_d      = len_q + 1'b1;
          if (ch[g_q] == CH_END) begin
            state_d = FLUSH;
          end
        end else begin
          rv_d    = 1'b1;
          ra_d    = 1'b1;
          rt_d    = FMT_BAD;
          rs_d    = g_q;
          inc_bad = 1'b1;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        state_d = RESULT;
      end
      RESULT: begin
        rv_d = 1'b1;
        ra_d = 1'b0;
        rt_d = fmt_type;
        rs_d = g_q;
        unique case (1'b1)
          (fmt_type == FMT_REG): inc_reg = 1'b1;
          (fmt_type == FMT_MEM): inc_mem = 1'b1;
          default:               inc_bad = 1'b1;
        endcase
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= SRC_W'(N_SRC - 1);
      len_q   <= '0;
      chk_q   <= CH_NUL;
      rv_q    <= 1'b0;
      rs_q    <= '0;
      rt_q    <= FMT_BAD;
      ra_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      rv_q    <= rv_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      ra_q    <= ra_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (reset) begin
        cnt_reg_q[i] <= '0;
        cnt_mem_q[i] <= '0;
        cnt_bad_q[i] <= '0;
      end else if (g_q == SRC_W'(i)) begin
        if (inc_reg && cnt_reg_q[i] != '1) cnt_reg_q[i] <= cnt_reg_q[i] + 1'b1;
        if (inc_mem && cnt_mem_q[i] != '1) cnt_mem_q[i] <= cnt_mem_q[i] + 1'b1;
        if (inc_bad && cnt_bad_q[i] != '1) cnt_bad_q[i] <= cnt_bad_q[i] + 1'b1;
      end
    end
  end

  assign src_ready    = reset ? '0 : ready;
  assign chk_char     = chk_q;
  assign result_valid = rv_q;
  assign result_src   = rs_q;
  assign result_type  = rt_q;
  assign result_abort = ra_q;
  assign cnt_reg      = cnt_reg_q[cnt_sel];
  assign cnt_mem      = cnt_mem_q[cnt_sel];
  assign cnt_bad      = cnt_bad_q[cnt_sel];

endmodule
